bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 149 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and display bus of the sequential binary-to-BCD converter.
// The master requests conversions; the slave (converter) drives status and digits.
interface bin2bcd_seq_if #(
  parameter int WIDTH = 27
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       d1, d2, d3, d4, d5, d6, d7, d8;

  modport master (
    output start, value,
    input  busy, done, ovf, d1, d2, d3, d4, d5, d6, d7, d8
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, d1, d2, d3, d4, d5, d6, d7, d8
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: WIDTH shift cycles plus one commit cycle.
// Digits and ovf change only on the done edge, so the LED scanner never sees partial results.
module bin2bcd_seq #(
  parameter int WIDTH = 27   // legal range 4..27
) (
  input  logic          clk,
  input  logic          nreset,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_bin;
  logic [35:0]        r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_digits;
  logic               r_ovf;
  logic               r_done;
  logic [35:0]        w_bcd_adj;
  logic               w_busy;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;

  function automatic logic [3:0] f_add3(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE so requests while busy are dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_SHIFT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_FINISH;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    w_busy   = 1'b0;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        w_load = bus.start;
      end
      S_SHIFT: begin
        w_busy  = 1'b1;
        w_shift = 1'b1;
      end
      S_FINISH: begin
        w_busy   = 1'b1;
        w_finish = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Add-3 correction of all nine digits ahead of the shift
  always_comb begin
    w_bcd_adj = 36'd0;
    for (int i = 0; i < 9; i++) begin
      w_bcd_adj[i*4 +: 4] = f_add3(r_bcd[i*4 +: 4]);
    end
  end

  // Datapath: capture, shift, then commit digits with saturation above 99_999_999
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bin    <= '0;
      r_bcd    <= 36'd0;
      r_cnt    <= '0;
      r_digits <= 32'd0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_bin <= bus.value;
        r_bcd <= 36'd0;
        r_cnt <= CNT_W'(WIDTH);
      end else if (w_shift) begin
        r_bcd <= {w_bcd_adj[34:0], r_bin[WIDTH-1]};
        r_bin <= {r_bin[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (w_finish) begin
        r_ovf  <= (r_bcd[35:32] != 4'd0);
        r_done <= 1'b1;
        if (r_bcd[35:32] != 4'd0) begin
          r_digits <= 32'h9999_9999;
        end else begin
          r_digits <= r_bcd[31:0];
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.d1   = r_digits[3:0];
  assign bus.d2   = r_digits[7:4];
  assign bus.d3   = r_digits[11:8];
  assign bus.d4   = r_digits[15:12];
  assign bus.d5   = r_digits[19:16];
  assign bus.d6   = r_digits[23:20];
  assign bus.d7   = r_digits[27:24];
  assign bus.d8   = r_digits[31:28];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected digits come from a decimal model pushed to a
// scoreboard at each accepted start and popped at each done pulse.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic [31:0] dig;
    logic        ovf;
  } exp_t;

  logic clk;
  logic nreset;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  bin2bcd_seq_if #(.WIDTH(27)) bus ();

  bin2bcd_seq #(.WIDTH(27)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic exp_t model(input logic [26:0] v);
    exp_t        e;
    int unsigned x;
    x = 32'(v);
    e = '0;
    if (x > 32'd99999999) begin
      e.dig = 32'h9999_9999;
      e.ovf = 1'b1;
    end else begin
      e.ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        e.dig[i*4 +: 4] = 4'(x % 32'd10);
        x = x / 32'd10;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] shown();
    return {bus.d8, bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done (bounded); busy_ok clears if busy drops before done.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    do begin
      tick();
      cyc++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end while (!bus.done && cyc < 60);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " digits"}, 64'(shown()), 64'(e.dig));
      chk({tag, " ovf"}, 64'(bus.ovf), 64'(e.ovf));
    end else begin
      chk({tag, " scoreboard empty"}, 64'(sb.size()), 64'd1);
    end
  endtask

  task automatic run_conv(input string tag, input logic [26:0] v);
    int          cyc;
    bit          bok;
    logic [31:0] held;
    bus.value = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.value = ~v;
    sb.push_back(model(v));
    chk({tag, " busy after start"}, 64'(bus.busy), 64'd1);
    wait_done(cyc, bok);
    chk({tag, " latency"}, 64'(cyc), 64'd28);
    chk({tag, " busy held"}, 64'(bok), 64'd1);
    chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    check_result(tag);
    held = shown();
    tick();
    chk({tag, " done one cycle"}, 64'(bus.done), 64'd0);
    chk({tag, " digits hold"}, 64'(shown()), 64'(held));
  endtask

  initial begin
    int cyc;
    int ndone;
    int dcyc;
    bit bok;

    vectors     = 0;
    miscompares = 0;
    nreset      = 1'b0;
    bus.start   = 1'b0;
    bus.value   = 27'd0;
    tick();
    tick();
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset ovf", 64'(bus.ovf), 64'd0);
    chk("reset digits", 64'(shown()), 64'd0);
    nreset = 1'b1;
    tick();

    run_conv("T1 12345678", 27'd12345678);
    run_conv("T2 zero", 27'd0);
    run_conv("T2 99999999", 27'd99999999);
    run_conv("T3 100000000", 27'd100000000);
    run_conv("T3 seven", 27'd7);
    run_conv("max 27-bit", 27'h7FF_FFFF);

    // T4: a start while busy must be neither honoured nor queued
    bus.value = 27'd42;
    bus.start = 1'b1;
    tick();
    sb.push_back(model(27'd42));
    ndone = 0;
    dcyc  = 0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 5) begin
        bus.start = 1'b1;
        bus.value = 27'd999;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) begin
        ndone++;
        dcyc = i;
        chk("T4 busy at done", 64'(bus.busy), 64'd0);
        check_result("T4 42");
      end
    end
    chk("T4 done count", 64'(ndone), 64'd1);
    chk("T4 done cycle", 64'(dcyc), 64'd28);
    chk("T4 idle after", 64'(bus.busy), 64'd0);

    // T5: reset mid-conversion aborts with no done pulse
    bus.value = 27'd55555555;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    nreset = 1'b0;
    #1;
    chk("T5 abort busy", 64'(bus.busy), 64'd0);
    chk("T5 abort done", 64'(bus.done), 64'd0);
    chk("T5 abort ovf", 64'(bus.ovf), 64'd0);
    chk("T5 abort digits", 64'(shown()), 64'd0);
    tick();
    tick();
    nreset = 1'b1;
    ndone  = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus.done || bus.busy) ndone++;
    end
    chk("T5 quiet after release", 64'(ndone), 64'd0);
    run_conv("T5 one", 27'd1);

    // T6: start held high restarts every 29 cycles
    bus.value = 27'd1;
    bus.start = 1'b1;
    tick();
    sb.push_back(model(27'd1));
    for (int n = 0; n < 3; n++) begin
      wait_done(cyc, bok);
      chk("T6 period", 64'(cyc), (n == 0) ? 64'd28 : 64'd29);
      check_result("T6 track");
      if (n < 2) begin
        bus.value = 27'(n + 2);
        sb.push_back(model(27'(n + 2)));
      end else begin
        bus.start = 1'b0;
      end
    end
    tick();
    tick();
    chk("T6 idle at end", 64'(bus.busy), 64'd0);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
